crack_ctrl: RTL and testbench

Front-end controller for the key-search engine `crack`. It turns an operator start request into the one-cycle `en` handshake that `crack` expects, and tracks the search through to completion. When the search finishes it latches the 24-bit key and its valid flag, and drives six active-low seven-segment digits: blank when idle, a spinner while busy, the key in hex when found, and dashes when the search failed. It sits between the board I/O (button, HEX displays) and the `crack` instance in the top level.

---
 rtl/crack_pkg.sv | 22 ++
 rtl/crack_ctrl_hex7seg.sv | 11 +
 rtl/crack_ctrl.sv | 140 ++++++++++++++
 tb/tb_crack_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and seven-segment constants for the crack front-end controller.
package crack_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ARM  = 4'd1,
    S_KICK = 4'd2,
    S_BUSY = 4'd3,
    S_RUN  = 4'd4,
    S_SHOW = 4'd5
  } ctrl_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low gfedcba glyphs for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/crack_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import crack_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/crack_ctrl.sv
// Start handshake, completion tracking and result display for the crack engine.
// Optional search timer enabled by defining CRACK_CTRL_TIMER_EN.
//
// state | meaning
// IDLE  | display blank, waiting for a start edge
// ARM   | waiting for crack to report ready
// KICK  | one-cycle en pulse to crack
// BUSY  | waiting for crack to drop rdy
// RUN   | search in progress, waiting for rdy to return
// SHOW  | result latched and displayed; start edge re-arms
module crack_ctrl
  import crack_pkg::*;
#(
  parameter int SPIN_W = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        crack_en,
  input  logic        crack_rdy,
  input  logic [23:0] crack_key,
  input  logic        crack_key_valid,
  output logic        done,
  output logic        found,
  output logic [23:0] key_out,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [31:0] elapsed
);

  localparam logic [SPIN_W+2:0] SPIN_ONE = 1;

  ctrl_state_t       state;
  logic              start_q;
  logic              start_edge;
  logic [SPIN_W+2:0] spin_cnt;
  logic [SPIN_W+2:0] spin_inc;
  logic [6:0]        hex_q   [6];
  logic [6:0]        key_seg [6];

  assign start_edge = start & ~start_q;
  assign spin_inc   = spin_cnt + SPIN_ONE;

  // Decoders watch the live key so the glyphs can be latched on the same edge as key_out.
  for (genvar g = 0; g < 6; g++) begin : g_dec
    hex7seg u_dec (
      .nibble (crack_key[4*g +: 4]),
      .seg    (key_seg[g])
    );
  end

  function automatic logic [6:0] spin_seg(input logic [SPIN_W+2:0] cnt);
    logic [2:0] step;
    step = cnt[SPIN_W+2:SPIN_W];
    if (step >= 3'd6) step = step - 3'd6;
    return ~(7'b0000001 << step);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      crack_en <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      key_out  <= '0;
      spin_cnt <= '0;
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      start_q  <= start;
      crack_en <= 1'b0;
      if (state inside {S_ARM, S_KICK, S_BUSY, S_RUN}) begin
        spin_cnt <= spin_inc;
        hex_q[0] <= spin_seg(spin_inc);
      end
      case (state)
        S_IDLE, S_SHOW: begin
          if (start_edge) begin
            state    <= S_ARM;
            done     <= 1'b0;
            found    <= 1'b0;
            key_out  <= '0;
            spin_cnt <= '0;
            hex_q[0] <= spin_seg('0);
            for (int i = 1; i < 6; i++) hex_q[i] <= SEG_BLANK;
          end
        end
        S_ARM: begin
          if (crack_rdy) begin
            state    <= S_KICK;
            crack_en <= 1'b1;
          end
        end
        S_KICK: state <= S_BUSY;
        S_BUSY: if (!crack_rdy) state <= S_RUN;
        S_RUN: begin
          // Overrides the spinner update above on the completing edge.
          if (crack_rdy) begin
            state   <= S_SHOW;
            done    <= 1'b1;
            found   <= crack_key_valid;
            key_out <= crack_key_valid ? crack_key : '0;
            for (int i = 0; i < 6; i++) hex_q[i] <= crack_key_valid ? key_seg[i] : SEG_DASH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

`ifdef CRACK_CTRL_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == S_KICK) begin
      timer <= '0;
    end else if ((state == S_BUSY || state == S_RUN) && timer != 32'hFFFF_FFFF) begin
      timer <= timer + 32'd1;
    end
  end

  assign elapsed = timer;
`else
  assign elapsed = '0;
`endif

endmodule

// File: tb/tb_crack_ctrl.sv
// Self-checking bench for crack_ctrl with a behavioural crack responder.
module tb_crack_ctrl;

  localparam int SPIN_W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        crack_rdy = 1'b1;
  logic [23:0] crack_key = '0;
  logic        crack_key_valid = 1'b0;
  logic        crack_en, done, found;
  logic [23:0] key_out;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [31:0] elapsed;

  always #5 clk = ~clk;

  crack_ctrl #(.SPIN_W(SPIN_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .crack_en        (crack_en),
    .crack_rdy       (crack_rdy),
    .crack_key       (crack_key),
    .crack_key_valid (crack_key_valid),
    .done            (done),
    .found           (found),
    .key_out         (key_out),
    .hex0            (hex0),
    .hex1            (hex1),
    .hex2            (hex2),
    .hex3            (hex3),
    .hex4            (hex4),
    .hex5            (hex5),
    .elapsed         (elapsed)
  );

  typedef struct {
    logic [23:0] key;
    logic        valid;
    int          dly;
    int          len;
    int          aw;
    logic        tog;
    logic        exp_found;
    logic [23:0] exp_key;
    logic [41:0] exp_hex;
  } vec_t;

  vec_t tbl [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt, en_cyc, arm_c, spin_bad;
  bit spin_on = 0;
  logic [41:0] spin_act, spin_exp_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Lit segments (active-high gfedcba) per hex digit, inverted for the display.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  function automatic logic [41:0] model_hex(input logic [23:0] key, input logic valid);
    logic [41:0] r;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = valid ? glyph(key[4*i +: 4]) : 7'b0111111;
    return r;
  endfunction

  function automatic logic [6:0] spin_model(input int k);
    int m, s;
    m = k % (8 << SPIN_W);
    s = (m >> SPIN_W) % 6;
    return ~(7'd1 << s);
  endfunction

  function automatic logic [41:0] hex_all();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic observe();
    if (crack_en) begin
      en_cnt++;
      en_cyc = cyc;
    end
    if (spin_on) begin
      spin_exp_v = {{5{7'h7F}}, spin_model(cyc - arm_c)};
      if (hex_all() !== spin_exp_v) begin
        if (spin_bad == 0) spin_act = hex_all();
        spin_bad++;
      end
    end
  endtask

  task automatic run_search(input logic [23:0] key, input logic valid, input int dly, input int len,
                            input int aw, input logic tog, input logic exp_found,
                            input logic [23:0] exp_key, input logic [41:0] exp_hex);
    int t0, bad_hold;
    logic [31:0] exp_el;
`ifdef CRACK_CTRL_TIMER_EN
    exp_el = 32'(dly + len);
`else
    exp_el = 32'd0;
`endif
    en_cnt = 0;
    spin_bad = 0;
    bad_hold = 0;
    t0 = cyc;
    start = 1'b1;
    crack_rdy = (aw == 0);
    step();
    arm_c = cyc;
    spin_on = 1;
    observe();
    chk("arm_clears_result", 64'({done, found, key_out}), 64'd0);
    for (int w = 0; w < aw; w++) begin
      step();
      observe();
    end
    crack_rdy = 1'b1;
    step();
    observe();
    for (int c = 1; c <= dly + len; c++) begin
      step();
      observe();
      crack_rdy = !(c >= dly && c < dly + len);
      if (c < dly + len) begin
        start = tog ? 1'($urandom) : 1'b0;
        crack_key = 24'($urandom);
        crack_key_valid = 1'($urandom);
      end else begin
        start = 1'b0;
        crack_key = key;
        crack_key_valid = valid;
      end
    end
    spin_on = 0;
    step();
    observe();
    crack_key = ~key;
    crack_key_valid = ~valid;
    chk("done", 64'(done), 64'd1);
    chk("found", 64'(found), 64'(exp_found));
    chk("key_out", 64'(key_out), 64'(exp_key));
    chk("hex_result", 64'(hex_all()), 64'(exp_hex));
    chk("elapsed", 64'(elapsed), 64'(exp_el));
    for (int h = 0; h < 3; h++) begin
      step();
      observe();
      if (!done || found !== exp_found || key_out !== exp_key || hex_all() !== exp_hex
          || elapsed !== exp_el) bad_hold++;
    end
    chk("show_hold_bad_cycles", 64'(bad_hold), 64'd0);
    chk("en_pulse_count", 64'(en_cnt), 64'd1);
    chk("en_pulse_cycle", 64'(en_cyc - t0), 64'(2 + aw));
    if (spin_bad != 0)
      $display("spinner first deviation: display %0h", spin_act);
    chk("spinner_bad_cycles", 64'(spin_bad), 64'd0);
  endtask

  initial begin
    int idle_bad;
    logic [23:0] rk;
    logic rv;

    tbl[0] = '{24'h1A2B3C, 1'b1, 1, 100, 0, 1'b0, 1'b1, 24'h1A2B3C,
               {7'h79, 7'h08, 7'h24, 7'h03, 7'h30, 7'h46}};
    tbl[1] = '{24'hABCDEF, 1'b0, 1, 30, 0, 1'b0, 1'b0, 24'h000000, {6{7'h3F}}};
    tbl[2] = '{24'h1A2B3C, 1'b1, 3, 20, 2, 1'b1, 1'b1, 24'h1A2B3C,
               {7'h79, 7'h08, 7'h24, 7'h03, 7'h30, 7'h46}};
    tbl[3] = '{24'h9E8D07, 1'b1, 2, 5, 1, 1'b1, 1'b1, 24'h9E8D07,
               {7'h10, 7'h06, 7'h00, 7'h21, 7'h40, 7'h78}};

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_en", 64'(crack_en), 64'd0);
    chk("rst_result", 64'({done, found, key_out}), 64'd0);
    chk("rst_hex", 64'(hex_all()), 64'({6{7'h7F}}));
    chk("rst_elapsed", 64'(elapsed), 64'd0);
    rst_n = 1'b1;

    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (crack_en || done || hex_all() !== {6{7'h7F}}) idle_bad++;
    end
    chk("idle_quiet_bad_cycles", 64'(idle_bad), 64'd0);

    for (int i = 0; i < 4; i++)
      run_search(tbl[i].key, tbl[i].valid, tbl[i].dly, tbl[i].len, tbl[i].aw, tbl[i].tog,
                 tbl[i].exp_found, tbl[i].exp_key, tbl[i].exp_hex);

    for (int i = 0; i < 6; i++) begin
      rk = 24'($urandom);
      rv = 1'($urandom);
      run_search(rk, rv, $urandom_range(4, 1), $urandom_range(40, 1), $urandom_range(3, 0),
                 1'($urandom), rv, rv ? rk : 24'h0, model_hex(rk, rv));
    end

    // Reset while the search is running.
    start = 1'b1;
    crack_rdy = 1'b1;
    step();
    step();
    start = 1'b0;
    step();
    crack_rdy = 1'b0;
    repeat (4) step();
    chk("pre_rst_spinner_active", 64'(hex0 != 7'h7F), 64'd1);
    rst_n = 1'b0;
    crack_rdy = 1'b1;
    step();
    chk("midrun_rst_en", 64'(crack_en), 64'd0);
    chk("midrun_rst_result", 64'({done, found, key_out}), 64'd0);
    chk("midrun_rst_hex", 64'(hex_all()), 64'({6{7'h7F}}));
    chk("midrun_rst_elapsed", 64'(elapsed), 64'd0);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (crack_en || done || hex_all() !== {6{7'h7F}}) idle_bad++;
    end
    chk("post_rst_idle_bad_cycles", 64'(idle_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
